// File: rtl/font_loader.sv
// Byte-stream font loader: writes 8x16 glyph rows into the font RAM write port.
// Bit 7 of the leading byte selects a glyph load or a zero-fill of that glyph.
module font_loader #(
   parameter int unsigned ADDR_WIDTH     = 11,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_valid_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  s_ready_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int unsigned CODE_W  = 7;
   localparam int unsigned ROW_W   = 4;
   localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(15);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CLEAR,
      DONE
   } state_t;

   state_t               state, state_n;
   logic [CODE_W-1:0]    code, code_n;
   logic [ROW_W-1:0]     row, row_n, row_inc;
   logic [TIMER_W-1:0]   timer, timer_n;
   logic                 wr_en_n, done_n, err_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                 accept;

   assign s_ready_o = !rst_i && (state == IDLE || state == LOAD);
   assign busy_o    = (state != IDLE);
   assign accept    = s_valid_i && s_ready_o;
   assign row_inc   = row + ROW_W'(1);

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         code      <= '0;
         row       <= '0;
         timer     <= '0;
         wr_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         state     <= state_n;
         code      <= code_n;
         row       <= row_n;
         timer     <= timer_n;
         wr_en_o   <= wr_en_n;
         wr_addr_o <= addr_n;
         wr_data_o <= data_n;
         done_o    <= done_n;
         err_o     <= err_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      code_n  = code;
      row_n   = row;
      timer_n = timer;
      wr_en_n = 1'b0;
      addr_n  = wr_addr_o;
      data_n  = wr_data_o;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               code_n  = s_data_i[CODE_W-1:0];
               row_n   = '0;
               timer_n = '0;
               if (s_data_i[7]) begin
                  // first zero row is issued here so the 16 writes fill the CLEAR cycles
                  state_n = CLEAR;
                  wr_en_n = 1'b1;
                  addr_n  = ADDR_WIDTH'({s_data_i[CODE_W-1:0], ROW_W'(0)});
                  data_n  = '0;
               end else begin
                  state_n = LOAD;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               wr_en_n = 1'b1;
               addr_n  = ADDR_WIDTH'({code, row});
               data_n  = s_data_i;
               row_n   = row_inc;
               timer_n = '0;
               if (row == ROW_LAST) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               if (timer == TIMER_LAST) begin
                  err_n   = 1'b1;
                  state_n = IDLE;
                  timer_n = '0;
                  row_n   = '0;
               end else begin
                  timer_n = timer + TIMER_W'(1);
               end
            end
         end
         CLEAR: begin
            if (row == ROW_LAST) begin
               state_n = IDLE;
               row_n   = '0;
            end else begin
               row_n   = row_inc;
               wr_en_n = 1'b1;
               addr_n  = ADDR_WIDTH'({code, row_inc});
               data_n  = '0;
               done_n  = (row_inc == ROW_LAST);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_font_loader.sv
// Scoreboard bench for font_loader: driver pushes expected RAM writes, a monitor pops and compares.
module tb_font_loader;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        s_valid_i = 1'b0;
   logic [7:0]  s_data_i = 8'h00;
   logic        s_ready_o, wr_en_o, busy_o, done_o, err_o;
   logic [10:0] wr_addr_o;
   logic [7:0]  wr_data_o;

   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  data;
      logic        done;
   } wr_t;

   wr_t exp_q[$];
   int  err_due_q[$];
   int  done_cyc_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  last_acc = 0;
   int  exp_done = 0;
   int  err_seen = 0;

   always #20 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   font_loader #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
      .s_ready_o(s_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
   endtask

   // Monitor: compare every write, done and err pulse against the scoreboard
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (wr_en_o) begin
            if (exp_q.size() == 0) fail("unexpected_write");
            else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", 32'(wr_addr_o), 32'(e.addr));
               check("wr_data", 32'(wr_data_o), 32'(e.data));
               check("done_with_write", 32'(done_o), 32'(e.done));
            end
         end else if (done_o) fail("done_without_write");
         if (done_o) done_cyc_q.push_back(cyc);
         if (err_o) begin
            err_seen++;
            if (err_due_q.size() == 0) fail("unexpected_err");
            else check("err_cycle", 32'(cyc), 32'(err_due_q.pop_front()));
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap, output int waited);
      s_valid_i = 1'b0;
      repeat (gap) @(posedge clk_i);
      if (gap > 0) #1;
      s_valid_i = 1'b1;
      s_data_i  = b;
      waited = 0;
      forever begin
         @(negedge clk_i);
         if (s_ready_o) break;
         waited++;
         if (waited > 64) begin
            fail("ready_wait_bound");
            break;
         end
      end
      @(posedge clk_i);
      #1;
      s_valid_i = 1'b0;
      last_acc  = cyc;
   endtask

   // mode: 0 ramp rows, 1 constant 0xAA, 2 random
   task automatic load_glyph(input logic [6:0] code, input int mode, input int max_gap,
                             input int nrows, output int wcode);
      int w;
      logic [7:0] d;
      send({1'b0, code}, 0, wcode);
      for (int r = 0; r < nrows; r++) begin
         d = (mode == 0) ? 8'(r) : (mode == 1) ? 8'hAA : 8'($urandom);
         exp_q.push_back('{addr: {code, 4'(r)}, data: d, done: (r == 15)});
         send(d, int'($urandom_range(0, max_gap)), w);
      end
      if (nrows == 16) exp_done++;
   endtask

   task automatic clear_glyph(input logic [6:0] code);
      int w;
      for (int r = 0; r < 16; r++)
         exp_q.push_back('{addr: {code, 4'(r)}, data: 8'h00, done: (r == 15)});
      exp_done++;
      send({1'b1, code}, 0, w);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en_o), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr_o), 0);
      check({tag, "_wr_data"}, 32'(wr_data_o), 0);
      check({tag, "_done"}, 32'(done_o), 0);
      check({tag, "_err"}, 32'(err_o), 0);
      check({tag, "_busy"}, 32'(busy_o), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, nd;
      repeat (3) @(posedge clk_i);
      #1;
      check_idle_outputs("reset");
      check("ready_in_reset", 32'(s_ready_o), 0);
      rst_i = 1'b0;
      #1;
      check("ready_after_reset", 32'(s_ready_o), 1);

      // Ramp load of 'A'
      load_glyph(7'h41, 0, 0, 16, w);
      check("done_state_done", 32'(done_o), 1);
      check("done_state_ready", 32'(s_ready_o), 0);
      check("done_state_busy", 32'(busy_o), 1);
      @(posedge clk_i); #1;
      check("busy_after_done", 32'(busy_o), 0);

      // Gapped load of 0x7F
      load_glyph(7'h7F, 1, 5, 16, w);
      repeat (3) @(posedge clk_i); #1;

      // Clear 0x05 with valid held high into the next code byte
      clear_glyph(7'h05);
      load_glyph(7'h03, 2, 0, 16, w);
      check("clear_ready_low_cycles", 32'(w), 16);
      repeat (2) @(posedge clk_i); #1;

      // Timeout after three rows
      nd = done_cyc_q.size();
      load_glyph(7'h20, 2, 0, 3, w);
      err_due_q.push_back(last_acc + 8);
      repeat (12) @(posedge clk_i); #1;
      check("timeout_err_count", 32'(err_seen), 1);
      check("timeout_busy", 32'(busy_o), 0);
      check("timeout_no_done", 32'(done_cyc_q.size()), 32'(nd));

      // Reset in the middle of a load
      load_glyph(7'h10, 2, 0, 5, w);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("ready_during_rst", 32'(s_ready_o), 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check_idle_outputs("midreset");
      load_glyph(7'h11, 2, 0, 16, w);
      repeat (2) @(posedge clk_i); #1;

      // Back-to-back glyphs at full throughput
      load_glyph(7'h30, 2, 0, 16, w);
      load_glyph(7'h31, 2, 0, 16, w);
      check("b2b_wait_in_done", 32'(w), 1);
      repeat (2) @(posedge clk_i); #1;
      if (done_cyc_q.size() >= 2)
         check("b2b_done_spacing",
               32'(done_cyc_q[done_cyc_q.size()-1] - done_cyc_q[done_cyc_q.size()-2]), 18);
      else fail("b2b_done_missing");

      // Randomized mix of loads and clears
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) clear_glyph(7'($urandom));
         else load_glyph(7'($urandom), 2, 5, 16, w);
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
         #1;
      end

      repeat (20) @(posedge clk_i); #1;
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      check("err_queue_empty", 32'(err_due_q.size()), 0);
      check("done_count", 32'(done_cyc_q.size()), 32'(exp_done));
      check("final_busy", 32'(busy_o), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
